// File: rtl/cpu_pkg.sv
// Shared widths, writeback entry layout and skid-buffer state encoding
// for the execute->writeback path.
package cpu_pkg;

    localparam int DATA_WIDTH  = 32;
    localparam int RADDR_WIDTH = 4;

    typedef struct packed {
        logic [RADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0]  data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } buf_state_t;

endpackage

// File: rtl/wb_skid_fifo.sv
// Two-entry skid FIFO holding pending register writes, with a youngest-first
// forwarding lookup over the valid slots.
//
//   state | meaning
//   EMPTY | no pending writes, wb_valid low
//   ONE   | one entry at head, can still accept
//   FULL  | both slots occupied, upstream stalled
module wb_skid_fifo
    import cpu_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   flush,
    input  logic                   i_enq,
    input  wb_entry_t              i_enq_entry,
    input  logic                   i_deq,
    output logic                   o_valid,
    output logic                   o_full,
    output wb_entry_t              o_head,
    input  logic [RADDR_WIDTH-1:0] i_fwd_addr,
    output logic                   o_fwd_hit,
    output logic [DATA_WIDTH-1:0]  o_fwd_data
);

    buf_state_t r_state;
    wb_entry_t  r_slot [2];
    logic [1:0] r_slot_vld;
    logic       r_head;
    logic       r_tail;

    logic w_deq;
    logic w_young;
    logic w_young_hit;
    logic w_old_hit;

    assign o_valid = (r_state != EMPTY);
    assign o_full  = (r_state == FULL);
    assign o_head  = r_slot[r_head];
    assign w_deq   = i_deq && o_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= EMPTY;
            r_slot[0]  <= '0;
            r_slot[1]  <= '0;
            r_slot_vld <= 2'b00;
            r_head     <= 1'b0;
            r_tail     <= 1'b0;
        end else if (flush) begin
            r_state    <= EMPTY;
            r_slot_vld <= 2'b00;
            r_head     <= 1'b0;
            r_tail     <= 1'b0;
        end else begin
            // In ONE the head and tail slots differ, so enq and deq never collide.
            if (i_enq) begin
                r_slot[r_tail]     <= i_enq_entry;
                r_slot_vld[r_tail] <= 1'b1;
                r_tail             <= ~r_tail;
            end
            if (w_deq) begin
                r_slot_vld[r_head] <= 1'b0;
                r_head             <= ~r_head;
            end
            case (r_state)
                EMPTY:   if (i_enq) r_state <= ONE;
                ONE: begin
                    if (i_enq && !w_deq)      r_state <= FULL;
                    else if (!i_enq && w_deq) r_state <= EMPTY;
                end
                FULL:    if (w_deq) r_state <= ONE;
                default: r_state <= EMPTY;
            endcase
        end
    end

    // The slot just behind the tail pointer always holds the youngest entry.
    assign w_young     = ~r_tail;
    assign w_young_hit = r_slot_vld[w_young] && (r_slot[w_young].addr == i_fwd_addr);
    assign w_old_hit   = r_slot_vld[r_tail]  && (r_slot[r_tail].addr  == i_fwd_addr);

    always_comb begin
        o_fwd_hit  = 1'b0;
        o_fwd_data = '0;
        if (w_young_hit) begin
            o_fwd_hit  = 1'b1;
            o_fwd_data = r_slot[w_young].data;
        end else if (w_old_hit) begin
            o_fwd_hit  = 1'b1;
            o_fwd_data = r_slot[r_tail].data;
        end
    end

endmodule

// File: rtl/alu_writeback_stage.sv
// Execute->writeback stage: accepts ALU results, holds the architectural N/Z
// flags and buffers register writes toward the register-file write port.
module alu_writeback_stage
    import cpu_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_WIDTH-1:0]  in_result,
    input  logic                   in_zero,
    input  logic                   in_negative,
    input  logic [RADDR_WIDTH-1:0] in_rd_addr,
    input  logic                   in_wr_en,
    input  logic                   in_set_flags,
    output logic                   wb_valid,
    input  logic                   wb_ready,
    output logic [RADDR_WIDTH-1:0] wb_addr,
    output logic [DATA_WIDTH-1:0]  wb_data,
    output logic                   flag_n,
    output logic                   flag_z,
    input  logic [RADDR_WIDTH-1:0] fwd_addr,
    output logic                   fwd_hit,
    output logic [DATA_WIDTH-1:0]  fwd_data
);

    logic      r_flag_n;
    logic      r_flag_z;
    logic      w_full;
    logic      w_accept;
    logic      w_enq;
    wb_entry_t w_enq_entry;
    wb_entry_t w_head;

    // Stalling all accepts while full keeps flag updates in program order with writes.
    assign in_ready    = !w_full;
    assign w_accept    = in_valid && in_ready && !flush;
    assign w_enq       = w_accept && in_wr_en;
    assign w_enq_entry = '{addr: in_rd_addr, data: in_result};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_flag_n <= 1'b0;
            r_flag_z <= 1'b0;
        end else if (w_accept && in_set_flags) begin
            r_flag_n <= in_negative;
            r_flag_z <= in_zero;
        end
    end

    wb_skid_fifo u_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .flush       (flush),
        .i_enq       (w_enq),
        .i_enq_entry (w_enq_entry),
        .i_deq       (wb_ready),
        .o_valid     (wb_valid),
        .o_full      (w_full),
        .o_head      (w_head),
        .i_fwd_addr  (fwd_addr),
        .o_fwd_hit   (fwd_hit),
        .o_fwd_data  (fwd_data)
    );

    assign wb_addr = w_head.addr;
    assign wb_data = w_head.data;
    assign flag_n  = r_flag_n;
    assign flag_z  = r_flag_z;

endmodule
